imem_uart_loader: RTL and testbench

//  Serial program loader: the write-side of the instruction memory the single-cycle CPU reads.
//  - Receives a framed program image over UART (8N1) and writes 32-bit words into imem at 0,4,8,..
//  - Holds the CPU in reset (cpu_reset) from power-up until a load completes with a good checksum.
//  - Frame: 0xA5 | N[15:8] | N[7:0] | N words, 4 bytes each, MSB first | XOR checksum of data bytes.

---
 rtl/imem_uart_loader_pkg.sv | 30 +++
 rtl/imem_uart_loader_if.sv | 25 ++
 rtl/imem_uart_loader_uart_rx_byte.sv | 84 ++++++++
 rtl/imem_uart_loader.sv | 151 +++++++++++++++
 tb/tb_imem_uart_loader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/imem_uart_loader_pkg.sv
// rtl/imem_uart_loader_pkg.sv - shared constants and types for the UART program loader
// Purpose: frame header byte, loader and UART receiver state encodings, frame-state helper.
// Ports: none (package).
package imem_uart_loader_pkg;

  localparam logic [7:0] LOADER_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // True while a frame is open: header accepted, not yet DONE/ERROR.
  function automatic logic in_frame(ld_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// rtl/imem_uart_loader_if.sv - serial input, imem write port and status bundle of the loader
// Purpose: groups the loader's non-clock signals.
// Ports (master = loader side):
//   uart_rx in; imem_we, imem_addr[31:0], imem_wdata[31:0] out;
//   cpu_reset, busy, load_done, load_error out.
interface imem_uart_loader_if;
  logic        uart_rx;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        load_done;
  logic        load_error;

  modport master (
    input  uart_rx,
    output imem_we, imem_addr, imem_wdata, cpu_reset, busy, load_done, load_error
  );

  modport slave (
    output uart_rx,
    input  imem_we, imem_addr, imem_wdata, cpu_reset, busy, load_done, load_error
  );
endinterface

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// rtl/imem_uart_loader_uart_rx_byte.sv - 8N1 UART byte receiver
// Purpose: synchronises rx, finds start bits, samples 8 data bits LSB first and the stop bit.
// Ports: clk, reset (async, active-high), rx (serial in, idle high),
//        rx_byte[7:0], rx_valid (good stop bit), rx_ferr (stop bit was 0, byte dropped).
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     r_state, w_next;
  logic [1:0]    r_sync;
  logic          r_rx_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_fall, w_tick, w_half;

  assign w_fall = r_rx_d & ~r_sync[1];
  assign w_tick = (r_cnt == LAST);
  assign w_half = (r_cnt == HALF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      // Line back high at the half-bit point: a glitch, not a start bit.
      RX_START: if (w_half) w_next = r_sync[1] ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && (r_bit == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync   <= 2'b11;
      r_rx_d   <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], rx};
      r_rx_d   <= r_sync[1];
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      // Baud counter restarts at every bit boundary and at the half-bit start check,
      // so each later sample lands mid-bit.
      if ((r_state == RX_IDLE) || w_tick || ((r_state == RX_START) && w_half)) r_cnt <= '0;
      else r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_IDLE) r_bit <= '0;
      if ((r_state == RX_DATA) && w_tick) begin
        r_shift <= {r_sync[1], r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
      if ((r_state == RX_STOP) && w_tick) begin
        if (r_sync[1]) begin
          rx_valid <= 1'b1;
          rx_byte  <= r_shift;
        end else begin
          rx_ferr <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART program loader writing the CPU instruction memory
// Purpose: receives A5 | N hi | N lo | N words MSB first | XOR checksum, writes words at 0,4,8..,
//          and holds the CPU in reset until a frame completes with a good checksum.
// Ports: clk, reset (async, active-high), bus (master): uart_rx in; imem_we/addr/wdata,
//        cpu_reset, busy, load_done, load_error out (all registered).
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 8,
  parameter int TIMEOUT_BITS = 160
) (
  input  logic               clk,
  input  logic               reset,
  imem_uart_loader_if.master bus
);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT);
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_WIDTH);

  logic [7:0]            w_byte;
  logic                  w_valid, w_ferr, w_hdr, w_timeout, w_abort, w_last_word;
  logic [15:0]           w_len;
  ld_state_e             r_state, w_next;
  logic [7:0]            r_len_hi, r_chk;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_word;     // first three bytes of the word being assembled
  logic [TW-1:0]         r_to_cnt;
  logic                  r_we, r_cpu_reset, r_busy, r_done, r_err;
  logic [31:0]           r_addr, r_wdata;
  logic                  w_busy, w_cpu_reset, w_done, w_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (bus.uart_rx),
    .rx_byte  (w_byte),
    .rx_valid (w_valid),
    .rx_ferr  (w_ferr)
  );

  assign w_len       = {r_len_hi, w_byte};
  assign w_hdr       = w_valid && (w_byte == LOADER_HDR);
  assign w_timeout   = in_frame(r_state) && !w_valid && (r_to_cnt == TW'(TO_LIMIT - 1));
  assign w_abort     = w_ferr || w_timeout;
  assign w_last_word = (r_byte_cnt == 2'd3) && (({1'b0, r_word_idx} + 1'b1) == r_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (w_hdr) w_next = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_abort)      w_next = ST_ERROR;
        else if (w_valid) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_abort) w_next = ST_ERROR;
        else if (w_valid) begin
          if (w_len == 16'd0)             w_next = ST_CHK;
          else if ({1'b0, w_len} > MAX_N) w_next = ST_ERROR;
          else                            w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_abort)                     w_next = ST_ERROR;
        else if (w_valid && w_last_word) w_next = ST_CHK;
      end
      ST_CHK: begin
        if (w_abort)      w_next = ST_ERROR;
        else if (w_valid) w_next = (w_byte == r_chk) ? ST_DONE : ST_ERROR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Status is a function of the state being entered; registering it below
  // makes the outputs track the state register exactly.
  always_comb begin
    w_busy      = in_frame(w_next);
    w_done      = (w_next == ST_DONE);
    w_err       = (w_next == ST_ERROR);
    w_cpu_reset = (w_next != ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_to_cnt    <= '0;
      r_len_hi    <= '0;
      r_len       <= '0;
      r_chk       <= '0;
      r_word_idx  <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
    end else begin
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_cpu_reset <= w_cpu_reset;
      r_we        <= 1'b0;
      if (!in_frame(r_state) || w_valid) r_to_cnt <= '0;
      else                               r_to_cnt <= r_to_cnt + 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (w_hdr) begin
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_chk      <= '0;
          end
        end
        ST_LEN_HI: if (w_valid) r_len_hi <= w_byte;
        ST_LEN_LO: if (w_valid) r_len <= w_len[ADDR_WIDTH:0];
        ST_DATA: begin
          if (w_valid) begin
            r_word     <= {r_word[15:0], w_byte};
            r_chk      <= r_chk ^ w_byte;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == 2'd3) begin
              r_we       <= 1'b1;
              r_addr     <= {{(30 - ADDR_WIDTH){1'b0}}, r_word_idx, 2'b00};
              r_wdata    <= {r_word, w_byte};
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.busy       = r_busy;
  assign bus.load_done  = r_done;
  assign bus.load_error = r_err;
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - directed frame vectors and corner-case sequences for imem_uart_loader
module tb_imem_uart_loader;
  localparam int CPB = 4;

  typedef struct packed {
    logic [127:0] bytes;   // frame, first byte in [127:120]
    logic [4:0]   nb;
    logic [1:0]   nwr;
    logic [95:0]  words;   // expected write data, first word in [95:64]
    logic         done;
    logic         err;
    logic         cpu;
    logic         busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_uart_loader_if bus ();

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(4), .TIMEOUT_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t        vec [7];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          back_to_back = 0;
  logic        prev_we = 1'b0;
  int          n_vec = 0;
  int          n_miss = 0;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
    if (bus.imem_we && prev_we) back_to_back++;
    prev_we = bus.imem_we;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string nm, input logic done, input logic err,
                            input logic cpu, input logic busy);
    chk({nm, " load_done"}, 32'(bus.load_done), 32'(done));
    chk({nm, " load_error"}, 32'(bus.load_error), 32'(err));
    chk({nm, " cpu_reset"}, 32'(bus.cpu_reset), 32'(cpu));
    chk({nm, " busy"}, 32'(bus.busy), 32'(busy));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_rx = stop;
    repeat (CPB) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    bus.uart_rx = 1'b1;
    reset = 1'b1;

    vec[0] = '{bytes: {8'h3C, 120'h0}, nb: 5'd1, nwr: 2'd0, words: 96'h0,
               done: 1'b0, err: 1'b0, cpu: 1'b1, busy: 1'b0};
    vec[1] = '{bytes: {64'hA500_0120_0800_052D, 64'h0}, nb: 5'd8, nwr: 2'd1,
               words: {32'h2008_0005, 64'h0}, done: 1'b1, err: 1'b0, cpu: 1'b0, busy: 1'b0};
    vec[2] = '{bytes: 128'hA500_0301_0203_0405_0607_0809_0A0B_0C0C, nb: 5'd16, nwr: 2'd3,
               words: 96'h0102_0304_0506_0708_090A_0B0C, done: 1'b1, err: 1'b0, cpu: 1'b0, busy: 1'b0};
    vec[3] = '{bytes: {64'hA500_0120_0800_052C, 64'h0}, nb: 5'd8, nwr: 2'd1,
               words: {32'h2008_0005, 64'h0}, done: 1'b0, err: 1'b1, cpu: 1'b1, busy: 1'b0};
    vec[4] = '{bytes: {24'hA5_0011, 104'h0}, nb: 5'd3, nwr: 2'd0, words: 96'h0,
               done: 1'b0, err: 1'b1, cpu: 1'b1, busy: 1'b0};
    vec[5] = '{bytes: {64'hA500_0120_0800_052D, 64'h0}, nb: 5'd8, nwr: 2'd1,
               words: {32'h2008_0005, 64'h0}, done: 1'b1, err: 1'b0, cpu: 1'b0, busy: 1'b0};
    vec[6] = '{bytes: {32'hA500_0000, 96'h0}, nb: 5'd4, nwr: 2'd0, words: 96'h0,
               done: 1'b1, err: 1'b0, cpu: 1'b0, busy: 1'b0};

    repeat (3) @(negedge clk);
    chk_status("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset imem_we", 32'(bus.imem_we), 32'd0);
    chk("reset imem_addr", bus.imem_addr, 32'd0);
    chk("reset imem_wdata", bus.imem_wdata, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      clear_log();
      for (int i = 0; i < int'(vec[k].nb); i++) send_byte(vec[k].bytes[127 - 8*i -: 8], 1'b1);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d write count", k), 32'(wr_addr.size()), 32'(vec[k].nwr));
      for (int i = 0; i < int'(vec[k].nwr) && i < wr_addr.size(); i++) begin
        chk($sformatf("v%0d addr%0d", k, i), wr_addr[i], 32'(4 * i));
        chk($sformatf("v%0d wdata%0d", k, i), wr_data[i], vec[k].words[95 - 32*i -: 32]);
      end
      chk_status($sformatf("v%0d", k), vec[k].done, vec[k].err, vec[k].cpu, vec[k].busy);
    end

    // Reload after DONE, then mid-frame silence after the length bytes.
    clear_log();
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    chk_status("reload hdr", 1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (40) @(negedge clk);
    chk("timeout pre busy", 32'(bus.busy), 32'd1);
    repeat (40) @(negedge clk);
    chk_status("timeout", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("timeout write count", 32'(wr_addr.size()), 32'd0);

    // Framing error on the second data byte.
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h08, 1'b0);
    repeat (4) @(negedge clk);
    chk_status("ferr", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ferr write count", 32'(wr_addr.size()), 32'd0);

    // Asynchronous reset in the middle of DATA, then a clean frame.
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    repeat (2) @(negedge clk);
    chk("mid busy", 32'(bus.busy), 32'd1);
    chk("mid write count", 32'(wr_addr.size()), 32'd1);
    chk("mid wdata", bus.imem_wdata, 32'h0102_0304);
    #2 reset = 1'b1;
    #1;
    chk_status("async rst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("async rst imem_we", 32'(bus.imem_we), 32'd0);
    chk("async rst imem_addr", bus.imem_addr, 32'd0);
    chk("async rst imem_wdata", bus.imem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    clear_log();
    for (int i = 0; i < 8; i++) send_byte(vec[1].bytes[127 - 8*i -: 8], 1'b1);
    repeat (4) @(negedge clk);
    chk("post rst write count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      chk("post rst addr", wr_addr[0], 32'd0);
      chk("post rst wdata", wr_data[0], 32'h2008_0005);
    end
    chk_status("post rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("back-to-back strobes", 32'(back_to_back), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
